// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, registered result and {N,Z,V,C} flag register.
// Define ALU_SEQ_MUL_EN to build opcode 14 as a multi-cycle shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam int         CW     = $clog2(WIDTH);
`endif
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             arith;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [3:0]       alu_flags;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [3:0]         mul_flags;
`endif

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

  // Single-cycle datapath: result and candidate flags for the presented op.
  always_comb begin
    sum     = '0;
    opb     = b;
    cin     = 1'b0;
    arith   = 1'b0;
    alu_res = '0;
    alu_c   = flags_q[0];
    alu_v   = 1'b0;
    alu_err = 1'b0;
    unique case (op)
      4'd0: arith = 1'b1;
      4'd1: begin
        arith = 1'b1;
        cin   = flags_q[0];
      end
      4'd2: begin
        arith = 1'b1;
        opb   = ~b;
        cin   = 1'b1;
      end
      4'd3: begin
        arith = 1'b1;
        opb   = ~b;
        cin   = flags_q[0];
      end
      4'd4:  alu_res = a & b;
      4'd5:  alu_res = a | b;
      4'd6:  alu_res = a ^ b;
      4'd7:  alu_res = ~a;
      4'd8: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
        alu_v   = a[WIDTH-1] ^ a[WIDTH-2];
      end
      4'd9: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'd10: begin
        alu_res = {a[WIDTH-2:0], flags_q[0]};
        alu_c   = a[WIDTH-1];
      end
      4'd11: begin
        alu_res = {flags_q[0], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'd12: begin
        alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'd13: alu_res = b;
      default: alu_err = 1'b1;
    endcase
    if (arith) begin
      sum     = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_v   = (a[WIDTH-1] == opb[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);
    end
    alu_flags = {alu_res[WIDTH-1], ~|alu_res, alu_v, alu_c};
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add step: add multiplicand into the high half, shift right.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
               (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
    mul_flags = {prod_nxt[2*WIDTH-1], ~|prod_nxt,
                 |prod_nxt[2*WIDTH-1:WIDTH],
                 |prod_nxt[2*WIDTH-1:WIDTH]};
  end
`endif

  // FSM next state; flags only load when entering DONE, which beats flag_clr.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flag_clr ? 4'h0 : flags_q;
    err_d       = err_q;
`ifdef ALU_SEQ_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (op == 4'd14) begin
            state_d = S_BUSY;
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
          end else
`endif
          begin
            state_d     = S_DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            err_d       = alu_err;
            if (!alu_err) flags_d = alu_flags;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        prod_d = prod_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          result_d    = prod_nxt[WIDTH-1:0];
          result_hi_d = prod_nxt[2*WIDTH-1:WIDTH];
          err_d       = 1'b0;
          flags_d     = mul_flags;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= 4'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiplier working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq, WIDTH=8.
// Follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flag_clr = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         err;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flag_clr(flag_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] h;
    logic [3:0] f;
    logic       e;
    int         lat;
    int         acc;
    logic [3:0] pf;
  } exp_t;

  exp_t       sb[$];
  exp_t       nil;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         sink_mode = 1;
  logic [3:0] mflags = 4'h0;
  bit         fresh = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic int ovf(input int x);
    return (x > 127 || x < -128) ? 1 : 0;
  endfunction

  function automatic exp_t lit(input logic [7:0] r, input logic [7:0] h,
                               input logic [3:0] f, input logic e,
                               input int lat);
    exp_t x;
    x.r = r; x.h = h; x.f = f; x.e = e;
    x.lat = lat; x.acc = 0; x.pf = 4'h0;
    return x;
  endfunction

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                 input logic [7:0] y, input logic [3:0] fl);
    exp_t e;
    int ua, ub, sa, sbv, c, s, r, h, cout, v, p;
    bit ismul;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sbv = int'($signed(y));
    c = int'(fl[0]);
    s = 0; r = 0; h = 0; p = 0; cout = c; v = 0; ismul = 0;
    e.e = 1'b0; e.lat = 1; e.acc = 0; e.pf = fl;
    case (o)
      4'd0: begin s = ua + ub; v = ovf(sa + sbv); end
      4'd1: begin s = ua + ub + c; v = ovf(sa + sbv + c); end
      4'd2: begin s = ua + (255 - ub) + 1; v = ovf(sa - sbv); end
      4'd3: begin s = ua + (255 - ub) + c; v = ovf(sa - sbv - 1 + c); end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: r = 255 - ua;
      4'd8: begin
        r = (ua * 2) % 256; cout = ua / 128; v = cout ^ (r / 128);
      end
      4'd9:  begin r = ua / 2; cout = ua % 2; end
      4'd10: begin r = (ua * 2) % 256 + c; cout = ua / 128; end
      4'd11: begin r = c * 128 + ua / 2; cout = ua % 2; end
      4'd12: begin r = (sa >>> 1) & 255; cout = ua % 2; end
      4'd13: r = ub;
`ifdef ALU_SEQ_MUL_EN
      4'd14: begin
        p = ua * ub; r = p % 256; h = p / 256; e.lat = W + 1; ismul = 1;
      end
`endif
      default: e.e = 1'b1;
    endcase
    if (o <= 4'd3) begin
      r = s % 256;
      cout = s / 256;
    end
    e.r = 8'(r);
    e.h = 8'(h);
    if (e.e) begin
      e.r = '0; e.h = '0; e.f = fl;
    end else if (ismul) begin
      e.f = {h >= 128, p == 0, h != 0, h != 0};
    end else begin
      e.f = {r >= 128, r == 0, v != 0, cout != 0};
    end
    return e;
  endfunction

  // Present one request, hold until accepted, then queue its expectation.
  task automatic issue(input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input bit clr,
                       input bit use_lit, input exp_t le);
    exp_t e;
    bit   acc;
    int   k;
    acc = 1'b0;
    k = 0;
    e = model(o, x, y, mflags);
    if (use_lit) e = le;
    e.pf = mflags;
    if (clr && e.e) e.f = 4'h0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; flag_clr = clr;
    while (!acc && k < 50) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        k++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    flag_clr = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'(acc), 32'd1);
    end else begin
      e.acc = cyc - 1;
      mflags = e.f;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    sink_mode = 1;
    while ((sb.size() != 0 || out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(k < 100), 32'd1);
  endtask

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      fresh = 1'b1;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        if (fresh)
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        chk("out_rhfe", {11'd0, result, result_hi, flags, err},
            {11'd0, sb[0].r, sb[0].h, sb[0].f, sb[0].e});
        if (!out_ready) begin
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          fresh = 1'b0;
        end else begin
          void'(sb.pop_front());
          fresh = 1'b1;
        end
      end
    end else if (sb.size() != 0) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("busy_flags", 32'(flags), 32'(sb[0].pf));
      if (cyc - sb[0].acc > sb[0].lat) begin
        chk("result_timeout", 32'(out_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state",
        {9'd0, in_ready, out_valid, result, result_hi, flags, err},
        {9'd0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0});
    rst = 1'b0;

    issue(4'd0, 8'hFF, 8'h01, 0, 1, lit(8'h00, 8'h00, 4'b0101, 0, 1));
    issue(4'd1, 8'h10, 8'h20, 0, 1, lit(8'h31, 8'h00, 4'b0000, 0, 1));
    issue(4'd2, 8'h80, 8'h01, 0, 1, lit(8'h7F, 8'h00, 4'b0011, 0, 1));
    issue(4'd15, 8'h05, 8'h03, 0, 1, lit(8'h00, 8'h00, 4'b0011, 1, 1));
`ifdef ALU_SEQ_MUL_EN
    issue(4'd14, 8'hFF, 8'hFF, 0, 1, lit(8'h01, 8'hFE, 4'b1011, 0, 9));
`else
    issue(4'd14, 8'hFF, 8'hFF, 0, 1, lit(8'h00, 8'h00, 4'b0011, 1, 1));
`endif
    drain();

    sink_mode = 0;
    issue(4'd0, 8'h03, 8'h04, 0, 1, lit(8'h07, 8'h00, 4'b0000, 0, 1));
    repeat (3) @(negedge clk);
    sink_mode = 1;
    issue(4'd0, 8'hF0, 8'h20, 0, 1, lit(8'h10, 8'h00, 4'b0001, 0, 1));
    drain();

    chk("pre_clr_flags", 32'(flags), 32'h1);
    @(negedge clk);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    mflags = 4'h0;
    @(negedge clk);
    chk("flag_clr", 32'(flags), 32'h0);

    issue(4'd0, 8'h7F, 8'h01, 1, 1, lit(8'h80, 8'h00, 4'b1010, 0, 1));
    drain();

`ifdef ALU_SEQ_MUL_EN
    issue(4'd14, 8'h12, 8'h34, 0, 0, nil);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    mflags = 4'h0;
    @(negedge clk);
    chk("mul_reset", {20'd0, out_valid, in_ready, flags, result, err},
        {20'd0, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0});
    rst = 1'b0;
    repeat (12) @(negedge clk);
`endif

    sink_mode = 2;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom % 16), 8'($urandom), 8'($urandom), 0, 0, nil);
      repeat ($urandom % 3) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
